i2c_reg_bank: RTL and testbench
===============================

# i2c_reg_bank

Parametrised, single-clock register bank behind the I2C slave byte interface. It maps a byte-addressed pointer onto NUM_RW read/write limit registers, NUM_RO read-only status registers, one control register and one self-clearing pulse register, each REG_BYTES wide. Multi-byte registers are updated atomically when their most-significant byte is written. Multi-byte reads return a coherent snapshot. It replaces the fixed-map limits register file in the safety monitor path.

## Interface
- NUM_RW, 8: number of RW limit registers.
- NUM_RO, 2: number of RO status registers.
- REG_BYTES, 4: bytes per register; must be 1, 2 or 4.
- PULSE_CYCLES, 3: clocks a nonzero pulse-register value is held.
- RW_RESET, all zero: flat NUM_RW*REG_BYTES*8 reset image of the RW registers (register 0 in the LSBs).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-clk pulse on I2C start or repeated start.
- stop  in  1  one-clk pulse on I2C stop.
- data_vld  in  1  one-clk pulse when a byte has been received or sent.
- r_w  in  1  current transfer direction: 1 = master read.
- rx_data  in  8  byte received from the master.
- tx_data  out  8  byte to send to the master.
- ro_data  in  NUM_RO*REG_BYTES*8  live status inputs.
- rw_q  out  NUM_RW*REG_BYTES*8  committed limit registers.
- ctrl_q  out  REG_BYTES*8  control register. Bit0 = lock.
- pulse_q  out  REG_BYTES*8  self-clearing pulse register.
- wr_err  out  1  sticky flag for a rejected write.
- ptr  out  8  current byte pointer, for debug.

## Operation
- **Address decode**
  - idx = ptr / REG_BYTES and lane = ptr % REG_BYTES.
  - idx 0..NUM_RW-1 selects the RW registers and the next NUM_RO indices select the RO registers.
  - IDX_CTRL = NUM_RW+NUM_RO and IDX_PULSE = IDX_CTRL+1.
  - Higher indices are unmapped: reads return 0x00 and writes are ignored without an error.
- **Pointer increment**: if ptr >= PTR_MAX = (IDX_PULSE+1)*REG_BYTES-1, ptr becomes 0; otherwise ptr becomes ptr+1.
- **FSM states** IDLE, PTR, WR, RD.
  - From any state, start → PTR. The pointer is kept, so write-pointer then repeated-start-read works.
  - From any state, stop → IDLE. Any uncommitted staging is discarded.
  - PTR, data_vld with r_w=0: ptr = rx_data, go to WR.
  - PTR or RD, data_vld with r_w=1: increment ptr, go to or stay in RD.
  - WR, data_vld with r_w=0: write rx_data into staging[lane], then increment ptr.
  - WR, data_vld with r_w=1: ignored.
- **Staging**: reloaded from the live register value whenever ptr enters a new idx (pointer load or boundary crossing). Lanes that are not written keep their old contents.
- **Commit**: the write to lane REG_BYTES-1 commits the whole staging register to the target.
  - RW target with lock=1: commit suppressed and wr_err set.
  - RO target: commit suppressed and wr_err set.
  - CTRL target: bit0 is stored. Bit1 written as 1 clears wr_err and is not stored. CTRL reads return bit1 = wr_err.
  - PULSE target: loads pulse_q and restarts the hold counter. CTRL and PULSE commits are never blocked by lock.
- **Pulse**: pulse_q is cleared to 0 after PULSE_CYCLES clocks. A committed zero clears it immediately.
- **Read snapshot**: whenever ptr is updated with lane==0 or to a new idx, and on start, the full addressed register is captured into snap. tx_data = snap[lane].
- **Simultaneous events**
  - rst beats everything, then start/stop, then data_vld.
  - start together with data_vld: the byte is ignored.
  - A commit and pulse expiry in the same clock: the commit wins.
  - A commit and a W1C of wr_err in the same clock: the set wins.

## Timing
- **Reset values**
  - State IDLE, ptr 0, rw_q = RW_RESET.
  - ctrl_q, pulse_q, tx_data, staging and snap are 0; wr_err is 0.
- **Pointer**: ptr updates on the clk edge after data_vld.
- **Commit**: the target register and wr_err change on the clk edge after data_vld of the MSB lane.
- **Read path**: snap and tx_data are valid at most 2 clks after data_vld or start, well within one SCL low phase.
- **Pulse width**: pulse_q is nonzero for exactly PULSE_CYCLES clocks, starting the clock after commit.
- **Reset mid-transfer**: all outputs return to reset values immediately; no partial commit survives.

## Structure
- **Package i2c_reg_bank_pkg**
  - State enum.
  - CTRL bit positions: LOCK=0, ERR=1.
  - Helper functions for the IDX_CTRL, IDX_PULSE and PTR_MAX computation.
- **Sub-module reg_bank_pulse_timer**
  - Load and count-down logic for pulse_q.
  - Parameters: width and PULSE_CYCLES.

## Test plan
- **Atomic write**: with REG_BYTES=4, start, write ptr 0x04, then 0x11 0x22 0x33, stop. rw_q[1] is unchanged. Repeat with a 4th byte 0x44, stop. rw_q[1] = 0x44332211 one clk after that byte.
- **Lock**: write CTRL = 0x01, then a full write to reg 0. rw_q[0] is unchanged and wr_err=1. Write CTRL = 0x03. wr_err=0 and lock stays 1.
- **Coherent read**: ro_data[0] = 0x000000FF, then start a read at ptr IDX_RO*4. Change ro_data to 0x00000100 after lane 0 is sent. Bytes read are FF 00 00 00.
- **Wrap**: NUM_RW=8, NUM_RO=2 gives PTR_MAX 47. Set ptr 46 and read 3 bytes. ptr sequence is 47, 0, 1, and the 3rd byte is lane 0 of reg 0.
- **Pulse**: write PULSE = 0x00000005. pulse_q = 5 for exactly 3 clks, then 0. A rewrite at clk 2 extends it 3 clks from the new commit.
- **Reset mid-write**: assert rst after 2 of 4 bytes. All outputs return to reset values, and a new full write then behaves normally.

Source files
------------

// File: rtl/i2c_reg_bank_pkg.sv
// Shared types and map helpers for the I2C register bank.
// The CTRL and PULSE indices sit directly after the RW and RO blocks.
package i2c_reg_bank_pkg;

    typedef enum logic [1:0] {IDLE, PTR, WR, RD} state_t;

    localparam int CTRL_LOCK = 0;
    localparam int CTRL_ERR  = 1;

    function automatic int idx_ctrl(input int nrw, input int nro);
        return nrw + nro;
    endfunction

    function automatic int idx_pulse(input int nrw, input int nro);
        return idx_ctrl(nrw, nro) + 1;
    endfunction

    function automatic int ptr_max(input int nrw, input int nro, input int rb);
        return (idx_pulse(nrw, nro) + 1) * rb - 1;
    endfunction

endpackage

// File: rtl/i2c_reg_bank_pulse_timer.sv
// Holds a loaded value on pulse_q for PULSE_CYCLES clocks, then clears it.
// A new load always wins over expiry and restarts the hold.
module reg_bank_pulse_timer
    import i2c_reg_bank_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int PULSE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] pulse_q
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= '0;
            cnt     <= '0;
        end else if (load) begin
            pulse_q <= load_val;
            cnt     <= CW'(PULSE_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            pulse_q <= '0;
        end
    end

endmodule

// File: rtl/i2c_reg_bank.sv
// Byte-addressed register bank behind an I2C slave byte interface.
// Writes stage a full register and commit on the MSB lane; reads return a captured snapshot.
module i2c_reg_bank
    import i2c_reg_bank_pkg::*;
#(
    parameter int NUM_RW       = 8,
    parameter int NUM_RO       = 2,
    parameter int REG_BYTES    = 4,
    parameter int PULSE_CYCLES = 3,
    parameter logic [NUM_RW*REG_BYTES*8-1:0] RW_RESET = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           data_vld,
    input  logic                           r_w,
    input  logic [7:0]                     rx_data,
    output logic [7:0]                     tx_data,
    input  logic [NUM_RO*REG_BYTES*8-1:0]  ro_data,
    output logic [NUM_RW*REG_BYTES*8-1:0]  rw_q,
    output logic [REG_BYTES*8-1:0]         ctrl_q,
    output logic [REG_BYTES*8-1:0]         pulse_q,
    output logic                           wr_err,
    output logic [7:0]                     ptr
);

    localparam int RB8   = REG_BYTES * 8;
    localparam int LSH   = $clog2(REG_BYTES);
    localparam int LW    = (REG_BYTES > 1) ? LSH : 1;
    localparam int IDX_C = idx_ctrl(NUM_RW, NUM_RO);
    localparam int IDX_P = idx_pulse(NUM_RW, NUM_RO);
    localparam logic [7:0] PTR_MAX = 8'(ptr_max(NUM_RW, NUM_RO, REG_BYTES));

    typedef logic [REG_BYTES-1:0][7:0] word_t;

    state_t state, state_nxt;
    logic ptr_ld, ptr_inc, stg_wr, commit, reload, cap;
    logic [7:0] ptr_nxt, idx, idx_nxt;
    logic [LW-1:0] lane, lane_nxt;
    word_t stg, snap, cval, live_nxt, rd_nxt;
    logic [NUM_RW-1:0][RB8-1:0] rw_r;
    logic [NUM_RO-1:0][RB8-1:0] ro_v;
    logic [NUM_RW-1:0] rw_we;
    logic err_set, err_clr, ctrl_we, pulse_ld;

    assign ro_v     = ro_data;
    assign rw_q     = rw_r;
    assign idx      = ptr >> LSH;
    assign idx_nxt  = ptr_nxt >> LSH;
    assign lane     = (REG_BYTES > 1) ? ptr[LW-1:0] : '0;
    assign lane_nxt = (REG_BYTES > 1) ? ptr_nxt[LW-1:0] : '0;
    assign tx_data  = snap[lane];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ptr_ld    = 1'b0;
        ptr_inc   = 1'b0;
        stg_wr    = 1'b0;
        if (start) begin
            state_nxt = PTR;
        end else if (stop) begin
            state_nxt = IDLE;
        end else if (data_vld) begin
            case (state)
                PTR: begin
                    if (r_w) begin
                        ptr_inc   = 1'b1;
                        state_nxt = RD;
                    end else begin
                        ptr_ld    = 1'b1;
                        state_nxt = WR;
                    end
                end
                RD: ptr_inc = r_w;
                WR: begin
                    stg_wr  = !r_w;
                    ptr_inc = !r_w;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        if (ptr_ld)       ptr_nxt = rx_data;
        else if (ptr_inc) ptr_nxt = (ptr >= PTR_MAX) ? 8'd0 : ptr + 8'd1;
    end

    assign reload = ptr_ld || (ptr_inc && idx_nxt != idx);
    assign cap    = start || ((ptr_ld || ptr_inc) && (lane_nxt == '0 || idx_nxt != idx));
    assign commit = stg_wr && (lane == LW'(REG_BYTES - 1));

    // Live view of the register the pointer is about to address; reads add wr_err on CTRL.
    always_comb begin
        live_nxt = '0;
        for (int i = 0; i < NUM_RW; i++)
            if (idx_nxt == 8'(i)) live_nxt = rw_r[i];
        for (int i = 0; i < NUM_RO; i++)
            if (idx_nxt == 8'(NUM_RW + i)) live_nxt = ro_v[i];
        if (idx_nxt == 8'(IDX_C)) live_nxt = ctrl_q;
        if (idx_nxt == 8'(IDX_P)) live_nxt = pulse_q;
        rd_nxt = live_nxt;
        if (idx_nxt == 8'(IDX_C)) rd_nxt[0][CTRL_ERR] = wr_err;
    end

    always_comb begin
        cval       = stg;
        cval[lane] = rx_data;
        rw_we      = '0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        ctrl_we    = 1'b0;
        pulse_ld   = 1'b0;
        if (commit) begin
            for (int i = 0; i < NUM_RW; i++)
                if (idx == 8'(i)) begin
                    if (ctrl_q[CTRL_LOCK]) err_set  = 1'b1;
                    else                   rw_we[i] = 1'b1;
                end
            for (int i = 0; i < NUM_RO; i++)
                if (idx == 8'(NUM_RW + i)) err_set = 1'b1;
            if (idx == 8'(IDX_C)) begin
                ctrl_we = 1'b1;
                err_clr = cval[0][CTRL_ERR];
            end
            if (idx == 8'(IDX_P)) pulse_ld = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            stg    <= '0;
            snap   <= '0;
            rw_r   <= RW_RESET;
            ctrl_q <= '0;
            wr_err <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            if (cap) snap <= rd_nxt;
            if (stop && !start) stg <= '0;
            else if (reload)    stg <= live_nxt;
            else if (stg_wr)    stg[lane] <= rx_data;
            for (int i = 0; i < NUM_RW; i++)
                if (rw_we[i]) rw_r[i] <= cval;
            if (ctrl_we) begin
                ctrl_q            <= '0;
                ctrl_q[CTRL_LOCK] <= cval[0][CTRL_LOCK];
            end
            if (err_set)      wr_err <= 1'b1;
            else if (err_clr) wr_err <= 1'b0;
        end
    end

    reg_bank_pulse_timer #(
        .WIDTH        (RB8),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulse (
        .clk      (clk),
        .rst      (rst),
        .load     (pulse_ld),
        .load_val (cval),
        .pulse_q  (pulse_q)
    );

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed scenarios plus random byte transactions against a transaction-level register model.
module tb_i2c_reg_bank;

    localparam int NRW     = 8;
    localparam int NRO     = 2;
    localparam int RB      = 4;
    localparam int IDX_C   = NRW + NRO;
    localparam int IDX_P   = IDX_C + 1;
    localparam int PTR_MAX = (IDX_P + 1) * RB - 1;
    localparam logic [NRW*32-1:0] RST_IMG =
        256'h8777_0007_7666_0006_6555_0005_5444_0004_4333_0003_3222_0002_2111_0001_10AB_00C3;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, data_vld = 1'b0, r_w = 1'b0;
    logic [7:0] rx_data = 8'd0, tx_data, ptr;
    logic [NRO-1:0][31:0] ro;
    logic [NRW*32-1:0] rw_q;
    logic [31:0] ctrl_q, pulse_q;
    logic wr_err;

    always #5 clk = ~clk;

    i2c_reg_bank #(
        .NUM_RW(NRW), .NUM_RO(NRO), .REG_BYTES(RB), .PULSE_CYCLES(3), .RW_RESET(RST_IMG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .data_vld(data_vld), .r_w(r_w),
        .rx_data(rx_data), .tx_data(tx_data), .ro_data(ro), .rw_q(rw_q), .ctrl_q(ctrl_q),
        .pulse_q(pulse_q), .wr_err(wr_err), .ptr(ptr)
    );

    int n_vec = 0, n_err = 0;
    logic [31:0] m_rw [NRW];
    logic        m_lock, m_err;
    logic [31:0] m_pulse;
    int          m_ptr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_inc(input int p);
        return (p >= PTR_MAX) ? 0 : p + 1;
    endfunction

    function automatic logic [31:0] m_live(input int i);
        if (i < NRW)       return m_rw[i];
        if (i < NRW + NRO) return ro[i - NRW];
        if (i == IDX_C)    return {31'd0, m_lock};
        if (i == IDX_P)    return m_pulse;
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_read(input int i);
        return m_live(i) | ((i == IDX_C && m_err) ? 32'h2 : 32'h0);
    endfunction

    task automatic m_commit(input int i, input logic [31:0] v);
        if (i < NRW) begin
            if (m_lock) m_err = 1'b1;
            else        m_rw[i] = v;
        end else if (i < NRW + NRO) begin
            m_err = 1'b1;
        end else if (i == IDX_C) begin
            m_lock = v[0];
            if (v[1]) m_err = 1'b0;
        end else if (i == IDX_P) begin
            m_pulse = v;
        end
    endtask

    task automatic m_reset;
        for (int i = 0; i < NRW; i++) m_rw[i] = RST_IMG[i*32 +: 32];
        m_lock = 1'b0; m_err = 1'b0; m_pulse = 32'd0; m_ptr = 0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic start_ev(input logic dir);
        start = 1'b1; r_w = dir; tick; start = 1'b0;
    endtask

    task automatic stop_ev;
        stop = 1'b1; tick; stop = 1'b0; tick;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_vld = 1'b1; r_w = 1'b0; rx_data = b; tick; data_vld = 1'b0;
    endtask

    task automatic read_byte;
        data_vld = 1'b1; r_w = 1'b1; tick; data_vld = 1'b0;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < NRW; i++)
            chk($sformatf("%s rw%0d", tag, i), rw_q[i*32 +: 32], m_rw[i]);
        chk({tag, " ctrl"}, ctrl_q, {31'd0, m_lock});
        chk({tag, " err"}, wr_err, m_err);
        chk({tag, " pulse"}, pulse_q, m_pulse);
        chk({tag, " ptr"}, ptr, m_ptr);
    endtask

    task automatic rst_check(input string tag);
        for (int i = 0; i < NRW; i++)
            chk($sformatf("%s rw%0d", tag, i), rw_q[i*32 +: 32], RST_IMG[i*32 +: 32]);
        chk({tag, " ptr"}, ptr, 0);
        chk({tag, " ctrl"}, ctrl_q, 0);
        chk({tag, " pulse"}, pulse_q, 0);
        chk({tag, " tx"}, tx_data, 0);
        chk({tag, " err"}, wr_err, 0);
    endtask

    task automatic wr_txn(input int p, input int n, input logic [47:0] d);
        logic [31:0] stg;
        int lane, idx, np;
        start_ev(1'b0);
        send_byte(p[7:0]);
        m_ptr = p;
        stg = m_live(p / RB);
        for (int k = 0; k < n; k++) begin
            lane = m_ptr % RB;
            idx  = m_ptr / RB;
            stg[lane*8 +: 8] = d[k*8 +: 8];
            if (lane == RB - 1) m_commit(idx, stg);
            send_byte(d[k*8 +: 8]);
            if (lane == RB - 1) begin
                chk("commit err", wr_err, m_err);
                if (idx < NRW) chk("commit rw", rw_q[idx*32 +: 32], m_rw[idx]);
            end
            np = m_inc(m_ptr);
            if (np / RB != idx) stg = m_live(np / RB);
            m_ptr = np;
        end
        stop_ev;
    endtask

    task automatic rd_txn(input int p, input int n);
        logic [31:0] snap;
        int np;
        start_ev(1'b0);
        send_byte(p[7:0]);
        m_ptr = p;
        start_ev(1'b1);
        snap = m_read(m_ptr / RB);
        for (int k = 0; k < n; k++) begin
            chk("rd byte", tx_data, snap[(m_ptr % RB)*8 +: 8]);
            read_byte;
            np = m_inc(m_ptr);
            if (np % RB == 0 || np / RB != m_ptr / RB) snap = m_read(np / RB);
            m_ptr = np;
            chk("rd ptr", ptr, m_ptr);
        end
        stop_ev;
    endtask

    initial begin
        int p, n, q;
        bit ok;
        logic [63:0] rnd;

        ro[0] = 32'hA5A5_0001;
        ro[1] = 32'h5A5A_0002;
        repeat (3) tick;
        rst_check("rst hold");
        rst = 1'b0;
        tick;
        rst_check("rst");
        m_reset;

        // atomic write: three lanes do nothing, the fourth commits
        wr_txn(4, 3, 48'h332211);
        check_state("atomic3");
        wr_txn(4, 4, 48'h44332211);
        chk("atomic rw1", rw_q[63:32], 32'h4433_2211);
        check_state("atomic4");

        // lock blocks RW commits; CTRL bit1 clears the error
        wr_txn(IDX_C * RB, 4, 48'h01);
        wr_txn(0, 4, 48'hDEAD_BEEF);
        chk("lock err", wr_err, 1);
        check_state("locked");
        wr_txn(IDX_C * RB, 4, 48'h03);
        chk("w1c err", wr_err, 0);
        chk("w1c lock", ctrl_q, 1);
        check_state("w1c");

        // coherent read of RO0 across a live change
        ro[0] = 32'h0000_00FF;
        start_ev(1'b0);
        send_byte(8'(NRW * RB));
        start_ev(1'b1);
        chk("coh b0", tx_data, 8'hFF);
        read_byte;
        ro[0] = 32'h0000_0100;
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("coh b%0d", k), tx_data, 8'h00);
            read_byte;
        end
        stop_ev;

        // pointer wrap at PTR_MAX
        rd_txn(PTR_MAX - 1, 3);
        chk("wrap ptr", ptr, 1);

        // pulse hold, then a rewrite that lands on the expiry clock
        start_ev(1'b0);
        send_byte(8'(IDX_P * RB));
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("pulse c0", pulse_q, 32'h5);
        tick; chk("pulse c1", pulse_q, 32'h5);
        tick; chk("pulse c2", pulse_q, 32'h5);
        tick; chk("pulse c3", pulse_q, 32'h0);
        start_ev(1'b0);
        send_byte(8'(IDX_P * RB));
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("pulse2 c0", pulse_q, 32'h5);
        start_ev(1'b0);
        chk("pulse2 c1", pulse_q, 32'h5);
        send_byte(8'(PTR_MAX));
        chk("pulse2 c2", pulse_q, 32'h5);
        send_byte(8'h09);
        chk("pulse3 c0", pulse_q, 32'h0900_0005);
        tick; chk("pulse3 c1", pulse_q, 32'h0900_0005);
        tick; chk("pulse3 c2", pulse_q, 32'h0900_0005);
        tick; chk("pulse3 c3", pulse_q, 32'h0);
        stop_ev;
        m_ptr = 0;
        check_state("pulse end");

        // reset in the middle of a write
        start_ev(1'b0);
        send_byte(8'd8);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #1 rst = 1'b1;
        #2 rst_check("rst mid");
        tick;
        rst = 1'b0;
        tick;
        m_reset;
        wr_txn(8, 4, 48'hCAFE_F00D);
        chk("post rst rw2", rw_q[95:64], 32'hCAFE_F00D);
        check_state("post rst");

        // random transactions; PULSE stays out of the write path
        repeat (150) begin
            if ($urandom_range(0, 3) == 0) begin
                ro[0] = $urandom;
                ro[1] = $urandom;
            end
            if ($urandom_range(0, 1) == 0) begin
                do begin
                    p = $urandom_range(0, 63);
                    n = $urandom_range(1, 6);
                    ok = 1'b1;
                    q = p;
                    for (int k = 0; k < n; k++) begin
                        if (q / RB == IDX_P) ok = 1'b0;
                        q = m_inc(q);
                    end
                end while (!ok);
                rnd = {$urandom, $urandom};
                wr_txn(p, n, rnd[47:0]);
                check_state("rnd wr");
            end else begin
                rd_txn($urandom_range(0, 63), $urandom_range(1, 6));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
